// File: rtl/ipc_key_scheduler.sv
// IPC command decoder and multi-key reply sequencer with a key event FIFO.
// Optional build macro IPC_FIFO_FLUSH_EN enables cmd 9 (flush FIFO, clear overflow).
module ipc_key_scheduler #(
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_KEYS   = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ipc_bit_strobe,
    input  logic       ipc_bit,
    output logic       ipc_reply_bit,
    output logic       ipc_busy,
    input  logic       key_valid,
    input  logic [8:0] key_code,
    input  logic       key_pressed,
    output logic [4:0] fifo_count,
    output logic       overflow
);
    // state   | meaning
    // S_IDLE  | collecting 4-bit command nibbles from the CPU
    // S_REPLY | shifting a status or keyboard reply out, one bit per strobe
    typedef enum logic {S_IDLE, S_REPLY} state_t;

    localparam int         AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0] DEPTH5 = 5'(FIFO_DEPTH);
    localparam logic [4:0] MAXK5  = 5'(MAX_KEYS);

    state_t state, state_nxt;

    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [1:0]    nib_cnt;
    logic [2:0]    cmd;
    logic [11:0]   sh;
    logic [6:0]    rem;
    logic [3:0]    seg_left;
    logic [2:0]    rec_left;

    logic [3:0]  cmd_word;
    logic [4:0]  n_clip;
    logic [2:0]  n_keys;
    logic [6:0]  kbd_len;
    logic [8:0]  head;
    logic [11:0] rec_word;
    logic        full, pop, push_ok, drop;
    logic        load_status, load_kbd, flush, shift_bit, seg_end;

    assign cmd_word = {cmd, ipc_bit};
    assign full     = (fifo_count == DEPTH5);
    assign n_clip   = (fifo_count > MAXK5) ? MAXK5 : fifo_count;
    assign n_keys   = n_clip[2:0];
    assign kbd_len  = 7'd4 + 7'(n_keys) * 7'd12;
    assign head     = mem[rd_ptr];
    assign rec_word = {1'b0, head[8:6], 2'b00, head[5:0]};
    assign ipc_busy = (state == S_REPLY);

    // A record is popped as the last bit of the previous segment leaves the shifter.
    assign pop     = seg_end;
    assign push_ok = key_valid && !flush && (!full || pop);
    assign drop    = key_valid && full && !pop && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        load_status = 1'b0;
        load_kbd    = 1'b0;
        flush       = 1'b0;
        shift_bit   = 1'b0;
        seg_end     = 1'b0;
        case (state)
            S_IDLE: begin
                if (ipc_bit_strobe && nib_cnt == 2'd3) begin
                    if (cmd_word == 4'h1) begin
                        load_status = 1'b1;
                        state_nxt   = S_REPLY;
                    end else if (cmd_word == 4'h8) begin
                        load_kbd  = 1'b1;
                        state_nxt = S_REPLY;
                    end
`ifdef IPC_FIFO_FLUSH_EN
                    else if (cmd_word == 4'h9) begin
                        flush = 1'b1;
                    end
`endif
                end
            end
            S_REPLY: begin
                if (ipc_bit_strobe) begin
                    shift_bit = 1'b1;
                    seg_end   = (seg_left == 4'd1) && (rec_left != 3'd0);
                    if (rem == 7'd1) state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nib_cnt       <= 2'd0;
            cmd           <= 3'd0;
            sh            <= 12'd0;
            rem           <= 7'd0;
            seg_left      <= 4'd0;
            rec_left      <= 3'd0;
            ipc_reply_bit <= 1'b0;
        end else begin
            if (ipc_bit_strobe && state == S_IDLE) begin
                nib_cnt <= nib_cnt + 2'd1;
                if (nib_cnt == 2'd3) begin
                    cmd           <= 3'd0;
                    ipc_reply_bit <= 1'b0;
                end else begin
                    cmd <= cmd_word[2:0];
                end
            end
            if (load_status) begin
                sh       <= {6'b0, overflow, fifo_count != 5'd0, 4'b0};
                rem      <= 7'd8;
                seg_left <= 4'd8;
                rec_left <= 3'd0;
            end else if (load_kbd) begin
                sh       <= {key_pressed, n_keys, 8'b0};
                rem      <= kbd_len;
                seg_left <= 4'd4;
                rec_left <= n_keys;
            end else if (shift_bit) begin
                ipc_reply_bit <= sh[11];
                rem           <= rem - 7'd1;
                if (seg_end) begin
                    sh       <= rec_word;
                    seg_left <= 4'd12;
                    rec_left <= rec_left - 3'd1;
                end else begin
                    sh       <= {sh[10:0], 1'b0};
                    seg_left <= seg_left - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= 5'd0;
            overflow   <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= 5'd0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + 1'b1;
                if (pop)     rd_ptr <= rd_ptr + 1'b1;
                if (push_ok && !pop)      fifo_count <= fifo_count + 5'd1;
                else if (pop && !push_ok) fifo_count <= fifo_count - 5'd1;
            end
            // A fresh drop wins over a same-cycle clear so the event is not lost.
            if (drop)                          overflow <= 1'b1;
            else if (load_status || flush)     overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= key_code;
    end
endmodule

// File: tb/tb_ipc_key_scheduler.sv
// Directed bench for ipc_key_scheduler: status/keyboard replies, FIFO limits, reset abort, cmd 9.
module tb_ipc_key_scheduler;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ipc_bit_strobe = 1'b0;
    logic       ipc_bit = 1'b0;
    logic       key_valid = 1'b0;
    logic [8:0] key_code = 9'd0;
    logic       key_pressed = 1'b0;
    logic       ipc_reply_bit, ipc_busy, overflow;
    logic [4:0] fifo_count;

    int n_chk = 0;
    int n_pass = 0;

    logic [8:0] keys [10] = '{9'h001, 9'h0C2, 9'h143, 9'h1FF, 9'h085,
                              9'h106, 9'h047, 9'h188, 9'h009, 9'h0AA};
    logic [8:0] fill [8]  = '{9'h011, 9'h122, 9'h033, 9'h144,
                              9'h055, 9'h166, 9'h077, 9'h188};
    logic [8:0] late_key  = 9'h1C3;

    ipc_key_scheduler dut (
        .clk(clk), .reset(reset),
        .ipc_bit_strobe(ipc_bit_strobe), .ipc_bit(ipc_bit),
        .ipc_reply_bit(ipc_reply_bit), .ipc_busy(ipc_busy),
        .key_valid(key_valid), .key_code(key_code), .key_pressed(key_pressed),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send_bit(input logic b, input logic kv, input logic [8:0] kc, output logic r);
        @(negedge clk);
        ipc_bit = b; ipc_bit_strobe = 1'b1; key_valid = kv; key_code = kc;
        @(negedge clk);
        ipc_bit = 1'b0; ipc_bit_strobe = 1'b0; key_valid = 1'b0;
        r = ipc_reply_bit;
    endtask

    task automatic send_cmd(input logic [3:0] c);
        logic r;
        for (int i = 3; i >= 0; i--) send_bit(c[i], 1'b0, 9'd0, r);
    endtask

    task automatic push_key(input logic [8:0] c);
        @(negedge clk);
        key_valid = 1'b1; key_code = c;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic read_reply(input int n, input int push_at, input logic [8:0] pc,
                              output logic [95:0] bits, output int bcnt);
        logic r;
        bits = '0;
        bcnt = 0;
        for (int i = 0; i < n; i++) begin
            if (ipc_busy) bcnt++;
            send_bit(1'b1, (i == push_at), pc, r);
            bits = {bits[94:0], r};
            if (i == push_at) begin
                check("coinc_count", fifo_count, 8);
                check("coinc_ovf", overflow, 0);
            end
        end
    endtask

    task automatic do_status(input string tag, input logic [7:0] exp);
        logic [95:0] bits;
        int bc;
        send_cmd(4'b0001);
        read_reply(8, -1, 9'd0, bits, bc);
        check(tag, bits, exp);
        check({tag, "_busy_strobes"}, bc, 8);
        check({tag, "_busy_end"}, ipc_busy, 0);
    endtask

    logic [95:0] bits, exp;
    int bc;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_reply", ipc_reply_bit, 0);
        check("rst_busy", ipc_busy, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", overflow, 0);
        reset = 1'b0;

        do_status("status0", 8'h00);

        // Single key, key held
        key_pressed = 1'b1;
        push_key(9'h1A5);
        check("one_count", fifo_count, 1);
        send_cmd(4'b1000);
        check("one_busy_start", ipc_busy, 1);
        check("one_decode_bit", ipc_reply_bit, 0);
        read_reply(16, -1, 9'd0, bits, bc);
        check("one_reply", bits, 16'b1001_0110_0010_0101);
        check("one_count_after", fifo_count, 0);
        check("one_busy_strobes", bc, 16);
        do_status("status_empty", 8'h00);

        // Overflow: 10 pushes into 8 entries, 7 reported
        key_pressed = 1'b0;
        for (int i = 0; i < 10; i++) push_key(keys[i]);
        check("ovf_flag", overflow, 1);
        check("ovf_count", fifo_count, 8);
        send_cmd(4'b1000);
        read_reply(88, -1, 9'd0, bits, bc);
        exp = 96'(4'b0111);
        for (int i = 0; i < 7; i++)
            exp = (exp << 12) | 96'({1'b0, keys[i][8:6], 2'b00, keys[i][5:0]});
        check("seven_reply", bits, exp);
        check("seven_count_after", fifo_count, 1);
        do_status("status_ovf", 8'h03);
        check("ovf_cleared", overflow, 0);
        do_status("status_nonempty", 8'h01);
        send_cmd(4'b1000);
        read_reply(16, -1, 9'd0, bits, bc);
        check("leftover_reply", bits, {4'b0001, 1'b0, keys[7][8:6], 2'b00, keys[7][5:0]});
        check("leftover_count", fifo_count, 0);

        // Push coincident with the first record pop while full
        for (int i = 0; i < 8; i++) push_key(fill[i]);
        check("fill_count", fifo_count, 8);
        check("fill_ovf", overflow, 0);
        send_cmd(4'b1000);
        read_reply(88, 3, late_key, bits, bc);
        exp = 96'(4'b0111);
        for (int i = 0; i < 7; i++)
            exp = (exp << 12) | 96'({1'b0, fill[i][8:6], 2'b00, fill[i][5:0]});
        check("coinc_reply", bits, exp);
        check("coinc_count_after", fifo_count, 2);
        send_cmd(4'b1000);
        read_reply(28, -1, 9'd0, bits, bc);
        check("coinc_tail", bits, {4'b0010,
                                   1'b0, fill[7][8:6], 2'b00, fill[7][5:0],
                                   1'b0, late_key[8:6], 2'b00, late_key[5:0]});
        check("coinc_tail_ovf", overflow, 0);

        // Empty keyboard read: 4-bit header, then a fresh command
        send_cmd(4'b1000);
        read_reply(4, -1, 9'd0, bits, bc);
        check("empty_reply", bits, 4'b0000);
        check("empty_busy_strobes", bc, 4);
        check("empty_busy_end", ipc_busy, 0);
        do_status("status_after_empty", 8'h00);

        // Reset in the middle of a reply
        key_pressed = 1'b1;
        push_key(9'h0F0);
        send_cmd(4'b1000);
        read_reply(5, -1, 9'd0, bits, bc);
        check("mid_busy", ipc_busy, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", ipc_busy, 0);
        check("abort_count", fifo_count, 0);
        check("abort_reply", ipc_reply_bit, 0);
        @(negedge clk);
        reset = 1'b0;
        do_status("status_after_abort", 8'h00);

        // Command 9
        for (int i = 0; i < 3; i++) push_key(keys[i]);
        send_cmd(4'b1001);
        check("cmd9_busy", ipc_busy, 0);
`ifdef IPC_FIFO_FLUSH_EN
        check("flush_count", fifo_count, 0);
        check("flush_ovf", overflow, 0);
        do_status("status_after_flush", 8'h00);
`else
        check("cmd9_count", fifo_count, 3);
        do_status("status_after_cmd9", 8'h01);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ipc_key_scheduler.md
Name: ipc_key_scheduler

Overview:
- Synchronous replacement for the IPC command/reply engine.
- Buffers keyboard events in a FIFO and decodes 4-bit IPC commands from the CPU-side bit stream.
- Sequences multi-key serial replies through one shared reply shifter, so up to MAX_KEYS keys are reported per read instead of one.
- Sits between the keyboard decoder and the ZX8302 IPC bit interface, clocked on clk_bus.

Parameters:
FIFO_DEPTH, 8, key FIFO entries; power of two, 2..16
MAX_KEYS, 7, max key records per keyboard reply; 1..7, fits the 3-bit NNN field

Ports:
clk  input  1  bus clock (clk_bus)
reset  input  1  reset, asynchronous, active-high
ipc_bit_strobe  input  1  single-clk-cycle pulse, one per IPC bit transferred
ipc_bit  input  1  command bit from CPU, sampled when ipc_bit_strobe=1
ipc_reply_bit  output  1  registered reply bit to CPU
ipc_busy  output  1  high while a reply is being shifted out
key_valid  input  1  one-cycle pulse: key_code holds a new key event
key_code  input  9  [8:6] ctrl/alt/shift, [5:0] QL keycode
key_pressed  input  1  level: last key still held
fifo_count  output  5  current FIFO occupancy, 0..FIFO_DEPTH
overflow  output  1  sticky flag: a key was dropped because the FIFO was full

Behaviour:
- Reset values: ipc_reply_bit=0, ipc_busy=0, fifo_count=0, overflow=0.
  - FIFO pointers, nibble counter, command shifter and reply counters all clear.
  - Reset mid-reply aborts the reply; no partial state survives.
- All state changes occur on posedge clk, and only in cycles where ipc_bit_strobe=1, except FIFO push.
- Idle (ipc_busy=0): each strobe shifts ipc_bit into cmd[3:0], LSB entering, MSB first; 2-bit nibble counter increments.
  - On the 4th bit the command is {cmd[2:0],ipc_bit}. Decode happens in that same strobe cycle; ipc_reply_bit<=0.
- Cmd 1 (status):
  - Reply is 8 bits, MSB first: {6'b0, overflow, fifo_count!=0}.
  - overflow clears at decode.
- Cmd 8 (keyboard):
  - At decode, N = min(fifo_count, MAX_KEYS) and P = key_pressed are snapshotted.
  - Reply is header nibble {P, N[2:0]}, then N records of 12 bits: nibble {0, code[8:6]}, byte {2'b00, code[5:0]}. Total length 4+12N bits.
  - Each record's FIFO entry is popped in the strobe cycle that loads that record into the shifter.
  - N=0 gives a 4-bit reply {P,000}.
- Any other command: no reply, ignored; the nibble counter continues.
- Reply state (ipc_busy=1): each strobe presents the next reply bit on ipc_reply_bit (registered, valid the cycle after the strobe) and decrements the remaining-bit counter (7 bits).
  - ipc_bit is ignored while busy.
  - ipc_busy falls in the cycle the last bit is presented; the next strobe is treated as a command bit and the nibble counter restarts at 0.
- FIFO:
  - Push on key_valid.
  - If full and no same-cycle pop, the key is dropped and overflow<=1.
  - Simultaneous push and pop, including when full: both are performed and fifo_count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Keys pushed after the cmd 8 snapshot stay queued for the next read.

Optional Feature:
- Macro IPC_FIFO_FLUSH_EN.
- Defined: cmd 9 gives no reply, empties the FIFO (fifo_count=0) and clears overflow in the decode cycle. A same-cycle key_valid push is discarded.
- Undefined: cmd 9 is an unknown command and is ignored.

Test Plan:
- Reset released, send cmd 0001 -> 8 reply strobes yield 00000000; ipc_busy high for exactly 8 strobes.
- Push key_code=9'h1A5 with key_pressed=1, send cmd 1000 -> reply 1001 0110 00100101 (16 bits); fifo_count 1->0; cmd 0001 then replies 00000000.
- Push 10 keys into the 8-deep FIFO -> overflow=1, fifo_count=8; cmd 1000 -> header 0111, 7 records in push order, fifo_count=1; cmd 0001 -> 00000011, overflow clears.
- key_valid coincident with a record-pop strobe while full -> fifo_count stays 8, overflow stays 0, new key appears last.
- Empty FIFO, key_pressed=0, cmd 1000 -> reply 0000, ipc_busy drops after 4 strobes; next 4 bits decode as a fresh command.
- Assert reset after 5 of 16 reply bits -> ipc_busy=0, fifo_count=0, ipc_reply_bit=0; next cmd 0001 replies 00000000. With IPC_FIFO_FLUSH_EN, cmd 1001 on 3 keys -> fifo_count=0, no reply.
